// File: rtl/ct_updown_param_pkg.sv
// Shared constants for the up/down modulo counter family: direction and
// bound-handling mode encodings.
package ct_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/ct_updown_param_if.sv
// Control/status bundle of the up/down counter; the counter is the slave,
// whoever drives count controls is the master.
interface ct_updown_param_if #(
    parameter int WIDTH = 3
);

    logic             sclr;
    logic             en;
    logic             up;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             at_bound;

    modport master (
        output sclr, en, up, sat, load, load_val,
        input  q, tc, wrap, at_bound
    );

    modport slave (
        input  sclr, en, up, sat, load, load_val,
        output q, tc, wrap, at_bound
    );

endinterface

// File: rtl/ct_updown_param_next_calc.sv
// Combinational next-count step for one enabled edge: increment/decrement,
// wrap or saturate at the bounds, and recovery of out-of-range counts.
module ct_next_calc
    import ct_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MAX_VAL = 7
) (
    input  logic [WIDTH-1:0] q,
    input  logic             up,
    input  logic             sat,
    output logic [WIDTH-1:0] nxt,
    output logic             wrap_evt,
    output logic             bound_evt
);

    localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   ZERO_EXT = {(WIDTH+1){1'b0}};
    localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX_VAL);

    logic [WIDTH:0] q_ext_s;
    logic [WIDTH:0] sum_s;

    // Step selection; an out-of-range count snaps to the bound it is heading for, without an event
    always_comb begin
        q_ext_s   = {1'b0, q};
        sum_s     = q_ext_s;
        wrap_evt  = 1'b0;
        bound_evt = 1'b0;
        if (up == DIR_UP) begin
            if (q_ext_s > MAX_EXT) begin
                sum_s = ZERO_EXT;
            end else if (q_ext_s == MAX_EXT) begin
                if (sat == MODE_WRAP) begin
                    sum_s    = ZERO_EXT;
                    wrap_evt = 1'b1;
                end else begin
                    sum_s     = q_ext_s;
                    bound_evt = 1'b1;
                end
            end else begin
                sum_s = q_ext_s + ONE_EXT;
            end
        end else begin
            if (q_ext_s > MAX_EXT) begin
                sum_s = MAX_EXT;
            end else if (q_ext_s == ZERO_EXT) begin
                if (sat == MODE_WRAP) begin
                    sum_s    = MAX_EXT;
                    wrap_evt = 1'b1;
                end else begin
                    sum_s     = q_ext_s;
                    bound_evt = 1'b1;
                end
            end else begin
                sum_s = q_ext_s - ONE_EXT;
            end
        end
    end

    // Final guard: the extended result can never leave the count range
    always_comb begin
        if (sum_s > MAX_EXT) begin
            nxt = MAX_Q;
        end else begin
            nxt = sum_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ct_updown_param.sv
// Parametrised up/down modulo counter with enable, parallel load, wrap/saturate
// mode, terminal-count, wrap-pulse and at-bound flags.
module ct_updown_param
    import ct_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MAX_VAL = 7,
    parameter int RST_VAL = 0
) (
    input  logic              clk,
    input  logic              clr_n,
    ct_updown_param_if.slave  bus
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] ZERO_Q  = {WIDTH{1'b0}};

    if ((WIDTH < 1) || (MAX_VAL >= (2 ** WIDTH)) || (RST_VAL > MAX_VAL) || (RST_VAL < 0)) begin : g_param_err
        $error("ct_updown_param: illegal WIDTH/MAX_VAL/RST_VAL combination");
    end

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic             at_bound_r;
    logic [WIDTH-1:0] nxt_s;
    logic             wrap_evt_s;
    logic             bound_evt_s;
    logic [WIDTH-1:0] load_clamped_s;

    ct_next_calc #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next_calc (
        .q         (q_r),
        .up        (bus.up),
        .sat       (bus.sat),
        .nxt       (nxt_s),
        .wrap_evt  (wrap_evt_s),
        .bound_evt (bound_evt_s)
    );

    // Loaded values above the top of the range are clamped to MAX_VAL
    always_comb begin
        if ({1'b0, bus.load_val} > MAX_EXT) begin
            load_clamped_s = MAX_Q;
        end else begin
            load_clamped_s = bus.load_val;
        end
    end

    // Count register and event flags, priority sclr > load > en > hold
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_r        <= RST_Q;
            wrap_r     <= 1'b0;
            at_bound_r <= 1'b0;
        end else if (bus.sclr) begin
            q_r        <= RST_Q;
            wrap_r     <= 1'b0;
            at_bound_r <= 1'b0;
        end else if (bus.load) begin
            q_r        <= load_clamped_s;
            wrap_r     <= 1'b0;
            at_bound_r <= 1'b0;
        end else if (bus.en) begin
            q_r        <= nxt_s;
            wrap_r     <= wrap_evt_s;
            at_bound_r <= bound_evt_s;
        end else begin
            q_r        <= q_r;
            wrap_r     <= 1'b0;
            at_bound_r <= 1'b0;
        end
    end

    assign bus.q        = q_r;
    assign bus.wrap     = wrap_r;
    assign bus.at_bound = at_bound_r;
    assign bus.tc       = ((bus.up == DIR_UP) && (q_r == MAX_Q)) ||
                          ((bus.up == DIR_DN) && (q_r == ZERO_Q));

endmodule

// File: tb/tb_ct_updown_param.sv
// Directed bench for ct_updown_param: three parameterisations share one clock;
// expected results are queued when stimulus is applied and checked after the edge.
module tb_ct_updown_param;

    logic clk = 1'b0;
    logic clr_n;

    always #5 clk = ~clk;

    ct_updown_param_if #(.WIDTH(3)) bus_a ();
    ct_updown_param_if #(.WIDTH(3)) bus_b ();
    ct_updown_param_if #(.WIDTH(4)) bus_c ();

    ct_updown_param #(.WIDTH(3), .MAX_VAL(7), .RST_VAL(0)) dut_a (
        .clk(clk), .clr_n(clr_n), .bus(bus_a)
    );
    ct_updown_param #(.WIDTH(3), .MAX_VAL(5), .RST_VAL(2)) dut_b (
        .clk(clk), .clr_n(clr_n), .bus(bus_b)
    );
    ct_updown_param #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) dut_c (
        .clk(clk), .clr_n(clr_n), .bus(bus_c)
    );

    typedef struct {
        string tag;
        int    dut;
        int    q;
        int    wrap;
        int    bnd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] obs_q(int d);
        case (d)
            0:       return 32'(bus_a.q);
            1:       return 32'(bus_b.q);
            default: return 32'(bus_c.q);
        endcase
    endfunction

    function automatic logic [31:0] obs_wrap(int d);
        case (d)
            0:       return 32'(bus_a.wrap);
            1:       return 32'(bus_b.wrap);
            default: return 32'(bus_c.wrap);
        endcase
    endfunction

    function automatic logic [31:0] obs_bnd(int d);
        case (d)
            0:       return 32'(bus_a.at_bound);
            1:       return 32'(bus_b.at_bound);
            default: return 32'(bus_c.at_bound);
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] observed, logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic expect_out(string tag, int d, int q, int w, int b);
        sb.push_back('{tag, d, q, w, b});
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".q"},        obs_q(e.dut),    32'(e.q));
            check({e.tag, ".wrap"},     obs_wrap(e.dut), 32'(e.wrap));
            check({e.tag, ".at_bound"}, obs_bnd(e.dut),  32'(e.bnd));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        int seq_dn [4];
        seq_dn = '{1, 0, 7, 6};

        clr_n = 1'b0;
        bus_a.sclr = 1'b0; bus_a.en = 1'b0; bus_a.up = 1'b1; bus_a.sat = 1'b0;
        bus_a.load = 1'b0; bus_a.load_val = 3'd0;
        bus_b.sclr = 1'b0; bus_b.en = 1'b0; bus_b.up = 1'b1; bus_b.sat = 1'b0;
        bus_b.load = 1'b0; bus_b.load_val = 3'd0;
        bus_c.sclr = 1'b0; bus_c.en = 1'b0; bus_c.up = 1'b1; bus_c.sat = 1'b0;
        bus_c.load = 1'b0; bus_c.load_val = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("rst_a", 0, 0, 0, 0);
        expect_out("rst_b", 1, 2, 0, 0);
        expect_out("rst_c", 2, 0, 0, 0);
        drain();
        clr_n = 1'b1;

        // up-count wrap modulo 8
        bus_a.en = 1'b1; bus_a.up = 1'b1; bus_a.sat = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            expect_out($sformatf("up_a%0d", i), 0, i % 8, (i == 8) ? 1 : 0, 0);
            tick();
        end
        expect_out("up_a_to2", 0, 2, 0, 0);
        tick();

        // down-count through zero
        bus_a.up = 1'b0;
        #1;
        check("tc_a_q2_dn", 32'(bus_a.tc), 32'd0);
        for (int i = 0; i < 4; i++) begin
            expect_out($sformatf("dn_a%0d", i), 0, seq_dn[i], (seq_dn[i] == 7) ? 1 : 0, 0);
            tick();
            if (seq_dn[i] == 0) check("tc_a_q0_dn", 32'(bus_a.tc), 32'd1);
        end

        // saturate at the top
        bus_a.up = 1'b1; bus_a.sat = 1'b1;
        #1;
        check("tc_a_q6_up", 32'(bus_a.tc), 32'd0);
        expect_out("sat_a0", 0, 7, 0, 0); tick();
        check("tc_a_q7_up", 32'(bus_a.tc), 32'd1);
        expect_out("sat_a1", 0, 7, 0, 1); tick();
        expect_out("sat_a2", 0, 7, 0, 1); tick();
        bus_a.en = 1'b0;
        expect_out("hold_a", 0, 7, 0, 0); tick();

        // load overrides en; out-of-range load clamps
        bus_a.en = 1'b1; bus_a.sat = 1'b0; bus_a.load = 1'b1; bus_a.load_val = 3'd3;
        bus_b.en = 1'b1; bus_b.load = 1'b1; bus_b.load_val = 3'd7;
        expect_out("load_a", 0, 3, 0, 0);
        expect_out("load_b_clamp", 1, 5, 0, 0);
        tick();
        bus_a.load = 1'b0;
        bus_b.load = 1'b0; bus_b.up = 1'b1; bus_b.sat = 1'b0;
        expect_out("inc_a_after_load", 0, 4, 0, 0);
        expect_out("wrap_b_5to0", 1, 0, 1, 0);
        tick();
        bus_a.en = 1'b0;
        bus_b.up = 1'b0; bus_b.sat = 1'b1;
        expect_out("hold_a4", 0, 4, 0, 0);
        expect_out("sat_b_q0_dn", 1, 0, 0, 1);
        tick();
        check("tc_b_q0_dn", 32'(bus_b.tc), 32'd1);

        // asynchronous reset between edges
        #2;
        clr_n = 1'b0;
        #1;
        expect_out("arst_a", 0, 0, 0, 0);
        expect_out("arst_b", 1, 2, 0, 0);
        drain();
        clr_n = 1'b1;
        bus_a.en = 1'b1; bus_a.up = 1'b1; bus_a.sat = 1'b0;
        bus_b.en = 1'b0;
        expect_out("post_rst_a", 0, 1, 0, 0);
        expect_out("post_rst_b", 1, 2, 0, 0);
        tick();

        // sclr beats load and en
        bus_a.sclr = 1'b1; bus_a.load = 1'b1; bus_a.load_val = 3'd5;
        bus_b.en = 1'b1; bus_b.load = 1'b1; bus_b.load_val = 3'd4;
        expect_out("sclr_a", 0, 0, 0, 0);
        expect_out("load_b4", 1, 4, 0, 0);
        tick();
        bus_a.sclr = 1'b0; bus_a.load = 1'b0; bus_a.up = 1'b0;
        bus_b.sclr = 1'b1; bus_b.load_val = 3'd1;
        expect_out("wrap_a_0to7", 0, 7, 1, 0);
        expect_out("sclr_b", 1, 2, 0, 0);
        tick();
        bus_a.en = 1'b0;
        bus_b.sclr = 1'b0; bus_b.load = 1'b0; bus_b.en = 1'b0;
        expect_out("wrap_a_clear", 0, 7, 0, 0);
        tick();

        // decade counter
        bus_c.en = 1'b1; bus_c.up = 1'b1; bus_c.sat = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            expect_out($sformatf("dec_c%0d", i), 2, i % 10, (i == 10) ? 1 : 0, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
